// File: rtl/apb_master_bridge.sv
// apb_master_bridge: converts a req/gnt/rvalid core-side port into APB3 master transfers.
// Ports: core side (req_i/gnt_o/addr_i/we_i/wdata_i -> rvalid_o/rdata_o/err_o),
//        APB side (paddr_o/pwdata_o/pwrite_o/psel_o/penable_o <- prdata_i/pready_i/pslverr_i).
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // A zero-width counter is illegal, so the disabled case keeps one dummy bit.
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          aligned;
  logic          timeout_hit;

  assign aligned     = (addr_i[1:0] == 2'b00);
  // Only meaningful in ACCESS; pready_i takes priority where this is used.
  assign timeout_hit = TO_EN && (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_i) state_nxt = aligned ? SETUP : RESP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready_i || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state flops, so psel/penable drop as soon as
  // the async reset clears the state.
  always_comb begin
    gnt_o     = 1'b0;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    rvalid_o  = 1'b0;
    case (state)
      IDLE:   gnt_o = req_i;
      SETUP:  psel_o = 1'b1;
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
      end
      RESP:   rvalid_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath: request latch, timeout counter, response capture.
  // rdata_o/err_o are written only on the cycle that enters RESP and are
  // zero in every other cycle, so they pulse together with rvalid_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      paddr_o  <= '0;
      pwdata_o <= '0;
      pwrite_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      cnt      <= '0;
    end else begin
      rdata_o <= '0;
      err_o   <= 1'b0;

      if (state == IDLE && req_i) begin
        if (aligned) begin
          paddr_o  <= addr_i;
          pwrite_o <= we_i;
          pwdata_o <= we_i ? wdata_i : '0;
        end else begin
          err_o <= 1'b1;
        end
      end

      if (state == SETUP) begin
        cnt <= '0;
      end else if (state == ACCESS && !pready_i && TO_EN) begin
        cnt <= cnt + 1'b1;
      end

      if (state == ACCESS) begin
        if (pready_i) begin
          rdata_o <= pwrite_o ? '0 : prdata_i;
          err_o   <= pslverr_i;
        end else if (timeout_hit) begin
          err_o <= 1'b1;
        end
      end
    end
  end

endmodule
